ram_write_buffer: RTL

- Write-posting buffer between the SD boot loader's RAM write channel and the RAM write port.
- Accepts single-cycle write requests (address and data) from a pulse-style client and queues them in a FIFO.
- Replays each entry to RAM with the same pulse-then-wait-ready handshake.
- Frees the SD controller from RAM latency between byte shifts. Also usable for any other write-only client.

---
 rtl/ram_write_buffer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ram_write_buffer.sv
// Posted-write buffer: a one-entry skid register feeds a FIFO that is replayed to
// RAM one entry at a time using a single-cycle strobe followed by a wait for ready.
module ram_write_buffer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_sig_write,
    input  logic [ADDR_W-1:0]        in_address,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_is_ready,
    output logic                     mem_sig_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_data,
    input  logic                     mem_is_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     idle,
    output logic                     overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("ram_write_buffer: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;

    logic                skid_valid_q, skid_valid_d;
    logic [ADDR_W-1:0]   skid_addr_q, skid_addr_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                overflow_q, overflow_d;
    logic [ADDR_W-1:0]   mem_address_q;
    logic [DATA_W-1:0]   mem_data_q;

    logic [ENTRY_W-1:0]  fifo_mem [DEPTH];

    logic                fifo_full;
    logic                fifo_empty;
    logic                capture;
    logic                push;
    logic                pop;
    logic                load;

    // The pop of a completed WAIT frees the head slot on the same edge, so a full
    // FIFO still accepts the skid then and the level does not dip.
    always_comb begin
        fifo_full  = (count_q == CNT_W'(DEPTH));
        fifo_empty = (count_q == '0);
        pop        = (state_q == ST_WAIT) && mem_is_ready;
        push       = skid_valid_q && (!fifo_full || pop);
        capture    = in_sig_write && !skid_valid_q;
        load       = (state_q == ST_IDLE) && !fifo_empty;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (!fifo_empty)  state_d = ST_ISSUE;
            ST_ISSUE:                   state_d = ST_WAIT;
            ST_WAIT:  if (mem_is_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        if (push) begin
            skid_valid_d = 1'b0;
        end
        if (capture) begin
            skid_valid_d = 1'b1;
            skid_addr_d  = in_address;
            skid_data_d  = in_data;
        end
        overflow_d = overflow_q || (in_sig_write && skid_valid_q);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= '0;
            skid_data_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage has no reset so it maps onto block RAM; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {skid_addr_q, skid_data_q};
        end
    end

    // Registered head read doubles as the RAM-side address/data hold register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_address_q <= '0;
            mem_data_q    <= '0;
        end else if (load) begin
            {mem_address_q, mem_data_q} <= fifo_mem[rd_ptr_q];
        end
    end

    assign in_is_ready   = !skid_valid_q;
    assign mem_sig_write = (state_q == ST_ISSUE);
    assign mem_address   = mem_address_q;
    assign mem_data      = mem_data_q;
    assign level         = count_q;
    assign idle          = !skid_valid_q && fifo_empty && (state_q == ST_IDLE);
    assign overflow      = overflow_q;

endmodule
